// File: rtl/gb_vram_arbiter_pkg.sv
// Shared constants and types for the Game Boy VRAM arbiter slice.
package gb_arb_pkg;

   localparam int NREQ_DEF = 3;
   localparam int AW_DEF   = 13;
   localparam int DW_DEF   = 8;

   // Requester slots; slot 0 is the real-time PPU fetcher.
   localparam int REQ_PPU  = 0;
   localparam int REQ_CPU  = 1;
   localparam int REQ_HPS  = 2;

   localparam int IDX_W_DEF = $clog2(NREQ_DEF);

   // Read-return tag for the default requester count.
   typedef struct packed {
      logic                 valid;
      logic [IDX_W_DEF-1:0] idx;
   } rd_tag_t;

   // Next round-robin start after requester w (w >= 1) is served; wraps to 1.
   function automatic int rr_next(input int w, input int nreq);
      return (w == nreq - 1) ? 1 : w + 1;
   endfunction

endpackage

// File: rtl/gb_vram_arbiter_if.sv
// Requester-side bus of the VRAM arbiter: flattened request lanes plus
// grant and read-return strobes.
interface gb_vram_if
   import gb_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF
) ();

   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    we;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;

   modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
   modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);

endinterface

// File: rtl/gb_vram_arbiter_rr_pick.sv
// Rotating-priority picker over slots 1..N-1, starting at ptr and wrapping
// back to 1. Slot 0 never takes part; win[0] is always 0.
module gb_rr_pick
   import gb_arb_pkg::*;
#(
   parameter int N  = NREQ_DEF,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:1] mask,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0] win
);

   logic found;

   // Scan ptr..N-1 first, then 1..ptr-1; first set mask bit wins.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int j = 1; j < N; j++) begin
         if (!found && (j >= int'(ptr)) && mask[j]) begin
            win[j] = 1'b1;
            found  = 1'b1;
         end
      end
      for (int j = 1; j < N; j++) begin
         if (!found && (j < int'(ptr)) && mask[j]) begin
            win[j] = 1'b1;
            found  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gb_vram_arbiter.sv
// Single-port VRAM arbiter: PPU (slot 0) has fixed priority, the other
// requesters rotate, and a per-requester wait counter forces a win once a
// requester has waited STARVE_LIMIT cycles. One access per cycle, reads
// return in accept order after 1+RD_LAT cycles.
module gb_vram_arbiter
   import gb_arb_pkg::*;
#(
   parameter int NREQ         = NREQ_DEF,
   parameter int AW           = AW_DEF,
   parameter int DW           = DW_DEF,
   parameter int RD_LAT       = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   gb_vram_if.slave      bus,
   output logic          mem_cs,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   typedef struct packed {
      logic          valid;
      logic [IW-1:0] idx;
   } tag_t;

   logic [IW-1:0]   rr_ptr;
   logic [CW-1:0]   cnt [1:NREQ-1];
   logic [NREQ-1:1] urg_mask;
   logic [NREQ-1:0] urg_win;
   logic [NREQ-1:0] norm_win;
   logic [NREQ-1:0] gnt_c;
   logic            acc;
   logic [IW-1:0]   win_idx;
   logic            win_we;
   logic [AW-1:0]   win_addr;
   logic [DW-1:0]   win_wdata;
   logic [IW-1:0]   issue_idx_p0;
   tag_t            rd_tag_p [RD_LAT];
   tag_t            tag_out;
   logic [NREQ-1:0] rvalid_c;
   logic [DW-1:0]   rdata_c;

   // A requester is urgent only while it still requests and has saturated.
   always_comb begin
      urg_mask = '0;
      for (int i = 1; i < NREQ; i++) begin
         urg_mask[i] = bus.req[i] && (cnt[i] == CW'(STARVE_LIMIT));
      end
   end

   gb_rr_pick #(.N(NREQ), .PW(IW)) u_pick_urg (
      .mask (urg_mask),
      .ptr  (rr_ptr),
      .win  (urg_win)
   );

   gb_rr_pick #(.N(NREQ), .PW(IW)) u_pick_norm (
      .mask (bus.req[NREQ-1:1]),
      .ptr  (rr_ptr),
      .win  (norm_win)
   );

   // Grant priority: urgent rotating winner, then PPU, then rotating winner.
   always_comb begin
      gnt_c = '0;
      if (!reset_n) begin
         gnt_c = '0;
      end else if (|urg_mask) begin
         gnt_c = urg_win;
      end else if (bus.req[REQ_PPU]) begin
         gnt_c[REQ_PPU] = 1'b1;
      end else begin
         gnt_c = norm_win;
      end
   end

   assign bus.gnt = gnt_c;

   // Encode the one-hot winner and select its request lane.
   always_comb begin
      acc     = |gnt_c;
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_c[i]) win_idx = IW'(i);
      end
      win_we    = bus.we[win_idx];
      win_addr  = bus.addr[int'(win_idx)*AW +: AW];
      win_wdata = bus.wdata[int'(win_idx)*DW +: DW];
   end

   // Rotation pointer advances past rotating winners; wait counters saturate.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= IW'(1);
         for (int i = 1; i < NREQ; i++) cnt[i] <= '0;
      end else begin
         if (acc && (win_idx != IW'(REQ_PPU))) begin
            rr_ptr <= IW'(rr_next(int'(win_idx), NREQ));
         end
         for (int i = 1; i < NREQ; i++) begin
            if (!bus.req[i] || gnt_c[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] != CW'(STARVE_LIMIT)) begin
               cnt[i] <= cnt[i] + CW'(1);
            end
         end
      end
   end

   // ---- stage p0: registered memory command for the accepted request ----
   // Drive the memory port in the cycle after each accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_cs       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         issue_idx_p0 <= '0;
      end else begin
         mem_cs <= acc;
         mem_we <= acc && win_we;
         if (acc) begin
            mem_addr     <= win_addr;
            mem_wdata    <= win_wdata;
            issue_idx_p0 <= win_idx;
         end
      end
   end

   // ---- stages p1..p(RD_LAT): read tags travel with the memory latency ----
   // Shift read tags so each lands on the cycle its data leaves the memory.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int s = 0; s < RD_LAT; s++) rd_tag_p[s] <= '0;
      end else begin
         rd_tag_p[0] <= '{valid: mem_cs && !mem_we, idx: issue_idx_p0};
         for (int s = 1; s < RD_LAT; s++) rd_tag_p[s] <= rd_tag_p[s-1];
      end
   end

   assign tag_out = rd_tag_p[RD_LAT-1];

   // Steer the returning data to its requester; bus idles at zero otherwise.
   always_comb begin
      rvalid_c = '0;
      rdata_c  = '0;
      if (tag_out.valid) begin
         rvalid_c[tag_out.idx] = 1'b1;
         rdata_c               = mem_rdata;
      end
   end

   assign bus.rvalid = rvalid_c;
   assign bus.rdata  = rdata_c;

endmodule

// File: tb/tb_gb_vram_arbiter.sv
// Bench for gb_vram_arbiter: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_gb_vram_arbiter;
   import gb_arb_pkg::*;

   localparam int N      = 3;
   localparam int AW     = 13;
   localparam int DW     = 8;
   localparam int RD_LAT = 1;
   localparam int LIM    = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          mem_cs;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   gb_vram_if #(.NREQ(N), .AW(AW), .DW(DW)) bus ();

   gb_vram_arbiter #(
      .NREQ(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_LIMIT(LIM)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .bus       (bus),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] init_val(input int a);
      return DW'(a * 37 + 11);
   endfunction

   // Memory macro model: one-cycle read latency, write on the strobe edge.
   logic [DW-1:0] tmem [0:(1<<AW)-1];
   initial begin
      for (int a = 0; a < (1 << AW); a++) tmem[a] = init_val(a);
      forever begin
         @(posedge clk);
         if (mem_cs === 1'b1) begin
            if (mem_we) tmem[mem_addr] = mem_wdata;
            else        mem_rdata      = tmem[mem_addr];
         end
      end
   end

   typedef struct {
      int            due;
      int            idx;
      logic [DW-1:0] data;
   } ret_t;

   int            total = 0;
   int            bad   = 0;
   int            cyc   = 0;
   int            wc  [N];
   int            age [N];
   int            rr;
   logic          p_act  [N];
   logic          p_we   [N];
   logic [AW-1:0] p_addr [N];
   logic [DW-1:0] p_wd   [N];
   logic          e_cs;
   logic          e_we;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_wd;
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   ret_t          ret_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] oh(input int w);
      return (w < 0) ? 32'd0 : (32'd1 << w);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         wc[i]  = 0;
         age[i] = 0;
      end
      rr   = 1;
      e_cs = 1'b0;
      e_we = 1'b0;
      ret_q.delete();
   endtask

   // Winner from the stated rules: urgent in rotation, else PPU, else rotation.
   function automatic int model_winner(input logic [N-1:0] rq);
      int ord[$];
      for (int k = 0; k < N - 1; k++) ord.push_back(((rr - 1 + k) % (N - 1)) + 1);
      foreach (ord[j]) if (rq[ord[j]] && wc[ord[j]] == LIM) return ord[j];
      if (rq[0]) return 0;
      foreach (ord[j]) if (rq[ord[j]]) return ord[j];
      return -1;
   endfunction

   task automatic model_update(input int w, input logic [N-1:0] rq);
      if (w >= 1) chk("fair_wait", 32'((age[w] + 1) <= (LIM + N - 1)), 32'd1);
      for (int i = 1; i < N; i++) begin
         if (rq[i] && w != i) begin
            age[i]++;
            if (wc[i] < LIM) wc[i]++;
         end else begin
            age[i] = 0;
            wc[i]  = 0;
         end
      end
      if (w >= 0) begin
         e_cs   = 1'b1;
         e_we   = p_we[w];
         e_addr = p_addr[w];
         e_wd   = p_wd[w];
         if (p_we[w]) shadow[p_addr[w]] = p_wd[w];
         else ret_q.push_back('{due: cyc + 1 + RD_LAT, idx: w, data: shadow[p_addr[w]]});
         if (w >= 1) rr = (w == N - 1) ? 1 : w + 1;
         p_act[w] = 1'b0;
      end else begin
         e_cs = 1'b0;
      end
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      p_act[i]  = 1'b1;
      p_we[i]   = we;
      p_addr[i] = a;
      p_wd[i]   = d;
   endtask

   task automatic clear_reqs();
      for (int i = 0; i < N; i++) p_act[i] = 1'b0;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         bus.req[i]            = p_act[i];
         bus.we[i]             = p_we[i];
         bus.addr[i*AW +: AW]  = p_addr[i];
         bus.wdata[i*DW +: DW] = p_wd[i];
      end
   endtask

   // One clock: drive, check at the falling edge, advance the model.
   // exp_w / exp_rv of -2 mean no extra directed expectation this cycle.
   task automatic run_cycle(input int exp_w, input int exp_rv);
      logic [N-1:0]  rq;
      logic [N-1:0]  erv;
      logic [DW-1:0] erd;
      logic          pop;
      int            w;
      drive();
      for (int i = 0; i < N; i++) rq[i] = p_act[i];
      if (!reset_n) model_reset();
      w   = reset_n ? model_winner(rq) : -1;
      erv = '0;
      erd = '0;
      pop = 1'b0;
      if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
         erv = N'(oh(ret_q[0].idx));
         erd = ret_q[0].data;
         pop = 1'b1;
      end
      @(negedge clk);
      chk("gnt", 32'(bus.gnt), oh(w));
      if (exp_w != -2) chk("gnt_directed", 32'(bus.gnt), oh(exp_w));
      chk("mem_cs", 32'(mem_cs), 32'(e_cs));
      if (e_cs) begin
         chk("mem_we", 32'(mem_we), 32'(e_we));
         chk("mem_addr", 32'(mem_addr), 32'(e_addr));
         if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
      end
      chk("rvalid", 32'(bus.rvalid), 32'(erv));
      chk("rdata", 32'(bus.rdata), 32'(erd));
      if (exp_rv != -2) chk("rvalid_directed", 32'(bus.rvalid), 32'(exp_rv));
      if (pop) void'(ret_q.pop_front());
      if (reset_n) model_update(w, rq);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_reqs();
      reset_n = 1'b0;
      run_cycle(-1, 0);
      reset_n = 1'b1;
   endtask

   initial begin
      for (int a = 0; a < (1 << AW); a++) shadow[a] = init_val(a);
      for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
      clear_reqs();
      model_reset();

      // Reset state, with every requester asserting: nothing may be granted.
      reset_n = 1'b0;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, AW'(i + 5), '0);
      run_cycle(-1, 0);
      run_cycle(-1, 0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      clear_reqs();
      reset_n = 1'b1;
      run_cycle(-1, 0);

      // Single read from the CPU.
      do_reset();
      set_req(REQ_CPU, 1'b0, 13'h0123, '0);
      run_cycle(REQ_CPU, 0);
      chk("single_cs", 32'(mem_cs), 32'd1);
      chk("single_addr", 32'(mem_addr), 32'h0123);
      run_cycle(-1, 0);
      run_cycle(-1, 3'b010);
      run_cycle(-1, 0);

      // All three request together: PPU, then CPU, then HPS.
      do_reset();
      set_req(REQ_PPU, 1'b0, 13'h0100, '0);
      set_req(REQ_CPU, 1'b0, 13'h0101, '0);
      set_req(REQ_HPS, 1'b0, 13'h0102, '0);
      run_cycle(REQ_PPU, 0);
      chk("simul_addr", 32'(mem_addr), 32'h0100);
      run_cycle(REQ_CPU, 0);
      run_cycle(REQ_HPS, 3'b001);
      run_cycle(-1, 3'b010);
      run_cycle(-1, 3'b100);
      run_cycle(-1, 0);

      // CPU and HPS hold requests: strict alternation.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         if (!p_act[REQ_CPU]) set_req(REQ_CPU, 1'b1, AW'(k), DW'(8'h30 + k));
         if (!p_act[REQ_HPS]) set_req(REQ_HPS, 1'b1, AW'(k + 8), DW'(8'h50 + k));
         run_cycle((k % 2 == 0) ? REQ_CPU : REQ_HPS, -2);
      end
      clear_reqs();
      run_cycle(-1, -2);

      // PPU and CPU hold requests: CPU breaks through on its ninth cycle.
      do_reset();
      for (int k = 0; k < 10; k++) begin
         if (!p_act[REQ_PPU]) set_req(REQ_PPU, 1'b1, AW'(k + 32), DW'(k));
         if (!p_act[REQ_CPU]) set_req(REQ_CPU, 1'b1, AW'(k + 48), DW'(k + 100));
         run_cycle((k == LIM) ? REQ_CPU : REQ_PPU, -2);
      end
      clear_reqs();
      run_cycle(-1, -2);

      // Back-to-back reads from CPU, HPS, CPU return in the same order.
      do_reset();
      set_req(REQ_CPU, 1'b0, 13'h0010, '0);
      set_req(REQ_HPS, 1'b0, 13'h0011, '0);
      run_cycle(REQ_CPU, 0);
      set_req(REQ_CPU, 1'b0, 13'h0012, '0);
      run_cycle(REQ_HPS, 0);
      run_cycle(REQ_CPU, 3'b010);
      run_cycle(-1, 3'b100);
      run_cycle(-1, 3'b010);
      run_cycle(-1, 0);

      // Reset lands while a read is in flight: it must never return.
      do_reset();
      set_req(REQ_CPU, 1'b0, 13'h0020, '0);
      run_cycle(REQ_CPU, 0);
      chk("midrst_cs_before", 32'(mem_cs), 32'd1);
      reset_n = 1'b0;
      run_cycle(-1, 0);
      run_cycle(-1, 0);
      reset_n = 1'b1;
      run_cycle(-1, 0);
      run_cycle(-1, 0);
      set_req(REQ_CPU, 1'b0, 13'h0021, '0);
      set_req(REQ_HPS, 1'b0, 13'h0022, '0);
      run_cycle(REQ_CPU, 0);
      run_cycle(REQ_HPS, 0);
      run_cycle(-1, 3'b010);
      run_cycle(-1, 3'b100);

      // Random traffic: holds until grant, occasional drops, small address pool.
      do_reset();
      for (int k = 0; k < 600; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!p_act[i]) begin
               if ($urandom_range(3) != 0)
                  set_req(i, 1'($urandom_range(1)), AW'($urandom_range(15)), DW'($urandom));
            end else if ($urandom_range(15) == 0) begin
               p_act[i] = 1'b0;
            end
         end
         run_cycle(-2, -2);
      end
      clear_reqs();
      for (int k = 0; k < 4; k++) run_cycle(-1, -2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
